// File: rtl/uart_rx_if.sv
// Receive-side handshake and status bundle of the uart_rx block.
// The receiver drives data/status and samples rx_ready from the consumer.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data, rx_valid, rx_done, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_done, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// One-bit-per-clock UART receiver: start, 5-8 data bits LSB first, optional
// parity, 1 or 2 stop bits, with a one-entry holding register on the output.
module uart_rx #(
    parameter bit DROP_ERR = 1'b0
) (
    input  logic       tx_clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [3:0] length,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       stop2,
    uart_rx_if.master  bus
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] DATA      = 3'd1;
    localparam logic [2:0] PARITY    = 3'd2;
    localparam logic [2:0] STOP1     = 3'd3;
    localparam logic [2:0] STOP2     = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    logic [2:0] state_reg, state_next;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic [3:0] len_reg;
    logic       par_en_reg, par_type_reg, stop2_reg;
    logic       perr_reg, ferr_reg;

    logic [7:0] hold_data_reg;
    logic       hold_valid_reg, hold_perr_reg, hold_ferr_reg, overrun_reg;
    logic       done_reg;
    logic       drop_flag_reg, drop_perr_reg, drop_ferr_reg;

    logic       len_bad, start_bad;
    logic [2:0] last_idx;
    logic [7:0] data_mask;
    logic       par_calc, par_exp;
    logic       complete, frame_perr, frame_ferr, load, xfer;

    // An illegal length is received as a full 8-bit frame
    assign len_bad   = (len_reg < 4'd5) || (len_reg > 4'd8);
    assign start_bad = (length < 4'd5) || (length > 4'd8);
    assign last_idx  = len_bad ? 3'd7 : 3'(len_reg - 4'd1);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            assign data_mask[gi] = len_bad || (len_reg > 4'(gi));
        end
    endgenerate

    assign par_calc   = ^(shift_reg & data_mask);
    assign par_exp    = par_type_reg ? par_calc : ~par_calc;

    assign complete   = ((state_reg == STOP1) && !stop2_reg) || (state_reg == STOP2);
    assign frame_perr = perr_reg;
    assign frame_ferr = ferr_reg | ~rx;
    assign load       = complete && !(DROP_ERR && (frame_perr || frame_ferr));
    assign xfer       = hold_valid_reg && bus.rx_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (!rx) state_next = DATA;
            DATA:      if (bit_cnt_reg == last_idx) state_next = par_en_reg ? PARITY : STOP1;
            PARITY:    state_next = STOP1;
            STOP1:     if (stop2_reg) state_next = STOP2;
                       else           state_next = frame_ferr ? WAIT_HIGH : IDLE;
            STOP2:     state_next = frame_ferr ? WAIT_HIGH : IDLE;
            WAIT_HIGH: if (rx) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            len_reg        <= '0;
            par_en_reg     <= 1'b0;
            par_type_reg   <= 1'b0;
            stop2_reg      <= 1'b0;
            perr_reg       <= 1'b0;
            ferr_reg       <= 1'b0;
            hold_data_reg  <= '0;
            hold_valid_reg <= 1'b0;
            hold_perr_reg  <= 1'b0;
            hold_ferr_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            done_reg       <= 1'b0;
            drop_flag_reg  <= 1'b0;
            drop_perr_reg  <= 1'b0;
            drop_ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (!rx) begin
                    len_reg      <= length;
                    par_en_reg   <= parity_en;
                    par_type_reg <= parity_type;
                    stop2_reg    <= stop2;
                    bit_cnt_reg  <= '0;
                    shift_reg    <= '0;
                    perr_reg     <= 1'b0;
                    ferr_reg     <= start_bad;
                end
                DATA: begin
                    shift_reg[bit_cnt_reg] <= rx;
                    bit_cnt_reg            <= bit_cnt_reg + 3'd1;
                end
                PARITY: perr_reg <= (rx != par_exp);
                STOP1:  if (!rx) ferr_reg <= 1'b1;
                default: ;
            endcase

            done_reg      <= complete;
            // A dropped frame shows its error flags for one cycle only
            drop_flag_reg <= complete && !load;
            drop_perr_reg <= frame_perr;
            drop_ferr_reg <= frame_ferr;

            if (load) begin
                hold_data_reg  <= shift_reg;
                hold_valid_reg <= 1'b1;
                hold_perr_reg  <= frame_perr;
                hold_ferr_reg  <= frame_ferr;
                overrun_reg    <= hold_valid_reg && !bus.rx_ready;
            end else if (xfer) begin
                hold_valid_reg <= 1'b0;
                hold_perr_reg  <= 1'b0;
                hold_ferr_reg  <= 1'b0;
                overrun_reg    <= 1'b0;
            end
        end
    end

    assign bus.rx_data    = hold_data_reg;
    assign bus.rx_valid   = hold_valid_reg;
    assign bus.rx_done    = done_reg;
    assign bus.parity_err = drop_flag_reg ? drop_perr_reg : hold_perr_reg;
    assign bus.frame_err  = drop_flag_reg ? drop_ferr_reg : hold_ferr_reg;
    assign bus.overrun    = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver that keeps errored frames (u0) and
// one that drops them (u1) share the same line and configuration.
module tb_uart_rx;
    logic       tx_clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [3:0] length = 4'd8;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       stop2 = 1'b0;
    logic       rx_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt;

    uart_rx_if bus0();
    uart_rx_if bus1();
    assign bus0.rx_ready = rx_ready;
    assign bus1.rx_ready = rx_ready;

    uart_rx #(.DROP_ERR(1'b0)) u0 (
        .tx_clk(tx_clk), .rst(rst), .rx(rx), .length(length), .parity_en(parity_en),
        .parity_type(parity_type), .stop2(stop2), .bus(bus0)
    );

    uart_rx #(.DROP_ERR(1'b1)) u1 (
        .tx_clk(tx_clk), .rst(rst), .rx(rx), .length(length), .parity_en(parity_en),
        .parity_type(parity_type), .stop2(stop2), .bus(bus1)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick();
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    // Sends one frame; returns just after the edge that sampled the last stop bit.
    task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                              input logic par, input logic s1, input bit has_s2,
                              input logic s2, input bit ready_last);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i]);
        if (has_par) send_bit(par);
        if (has_s2) begin
            send_bit(s1);
            if (ready_last) rx_ready = 1'b1;
            send_bit(s2);
        end else begin
            if (ready_last) rx_ready = 1'b1;
            send_bit(s1);
        end
        rx = 1'b1;
        rx_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_valid", bus0.rx_valid, 1'b0);
        check("rst_data", bus0.rx_data, 8'h00);
        check("rst_done", bus0.rx_done, 1'b0);
        check("rst_errs", {bus0.parity_err, bus0.frame_err, bus0.overrun}, 3'b000);
        rst = 1'b0;
        tick();

        // 1: 8 bits, even-style parity (XOR), good frame
        length = 4'd8; parity_en = 1'b1; parity_type = 1'b1; stop2 = 1'b0;
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_done", bus0.rx_done, 1'b1);
        check("t1_data", bus0.rx_data, 8'hA5);
        check("t1_valid", bus0.rx_valid, 1'b1);
        check("t1_errs", {bus0.parity_err, bus0.frame_err, bus0.overrun}, 3'b000);
        check("t1_drop_valid", bus1.rx_valid, 1'b1);
        tick();
        check("t1_done_once", bus0.rx_done, 1'b0);
        check("t1_hold", bus0.rx_valid, 1'b1);
        drain();
        check("t1_drained", bus0.rx_valid, 1'b0);
        check("t1_drop_drained", bus1.rx_valid, 1'b0);

        // 2: same frame with wrong parity
        send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t2_perr", bus0.parity_err, 1'b1);
        check("t2_data", bus0.rx_data, 8'hA5);
        check("t2_valid", bus0.rx_valid, 1'b1);
        check("t2_drop_done", bus1.rx_done, 1'b1);
        check("t2_drop_valid", bus1.rx_valid, 1'b0);
        check("t2_drop_perr", bus1.parity_err, 1'b1);
        tick();
        check("t2_drop_perr_gone", bus1.parity_err, 1'b0);
        check("t2_perr_held", bus0.parity_err, 1'b1);
        drain();
        check("t2_drained", {bus0.rx_valid, bus0.parity_err}, 2'b00);

        // 3: 5 bits, two stops, second stop low, then line held low
        length = 4'd5; parity_en = 1'b0; stop2 = 1'b1;
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_data", bus0.rx_data, 8'h1F);
        check("t3_ferr", bus0.frame_err, 1'b1);
        check("t3_valid", bus0.rx_valid, 1'b1);
        check("t3_drop_ferr", bus1.frame_err, 1'b1);
        check("t3_drop_valid", bus1.rx_valid, 1'b0);
        done_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus0.rx_done) done_cnt++;
        end
        check("t3_break_no_frames", done_cnt, 0);
        rx = 1'b1;
        drain();
        check("t3_drained", {bus0.rx_valid, bus0.frame_err}, 2'b00);
        send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t3_recover_data", bus0.rx_data, 8'h0A);
        check("t3_recover_ferr", bus0.frame_err, 1'b0);
        drain();

        // 4: back-to-back frames, zero gap
        length = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_done1", bus0.rx_done, 1'b1);
        check("t4_data1", bus0.rx_data, 8'h3C);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_done2", bus0.rx_done, 1'b1);
        check("t4_data2", bus0.rx_data, 8'hC3);
        check("t4_ovr", bus0.overrun, 1'b1);
        check("t4_drop_ovr", bus1.overrun, 1'b1);
        drain();
        check("t4_drained", {bus0.rx_valid, bus0.overrun}, 2'b00);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t4b_ovr", bus0.overrun, 1'b0);
        check("t4b_data", bus0.rx_data, 8'hC3);
        check("t4b_valid", bus0.rx_valid, 1'b1);

        // 5: reset during bit 3 while the holding register is full
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        rx = 1'b1;
        tick();
        check("t5_rst_valid", bus0.rx_valid, 1'b0);
        check("t5_rst_data", bus0.rx_data, 8'h00);
        check("t5_rst_flags", {bus0.rx_done, bus0.parity_err, bus0.frame_err, bus0.overrun}, 4'h0);
        rst = 1'b0;
        tick();
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_data", bus0.rx_data, 8'h55);
        check("t5_valid", bus0.rx_valid, 1'b1);
        check("t5_errs", {bus0.parity_err, bus0.frame_err, bus0.overrun}, 3'b000);
        drain();

        // 6: illegal length latched at start, 8 bits received
        length = 4'd3;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_ferr", bus0.frame_err, 1'b1);
        check("t6_data", bus0.rx_data, 8'h81);
        check("t6_drop_done", bus1.rx_done, 1'b1);
        check("t6_drop_valid", bus1.rx_valid, 1'b0);
        tick();
        drain();

        // 7: 7 bits with XNOR parity
        length = 4'd7; parity_en = 1'b1; parity_type = 1'b0;
        send_frame(8'h55, 7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t7_data", bus0.rx_data, 8'h55);
        check("t7_perr_ok", bus0.parity_err, 1'b0);
        drain();
        send_frame(8'h55, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t7_perr_bad", bus0.parity_err, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial-to-parallel UART receiver, the receive end of the team's uart_tx link. It uses the same one-bit-per-clock line rate and the same frame format: start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits. The frame configuration is shared with the transmitter. Received bytes are checked and presented on a valid/ready output with a one-entry holding register, with parity, framing and overrun status.

Parameters:
DROP_ERR, 0, 1 = frames with parity or framing error are not loaded into the holding register (rx_done still pulses and errors still reported); 0 = they are loaded.

Ports:
tx_clk  in  1  clock; one line bit per rising edge
rst  in  1  reset, synchronous, active-high
rx  in  1  serial line, idle high
length  in  4  data bits per frame, legal 5..8
parity_en  in  1  frame carries a parity bit
parity_type  in  1  1: expected parity = XOR of data bits; 0: XNOR of data bits
stop2  in  1  frame carries two stop bits
rx_ready  in  1  consumer accepts rx_data
rx_data  out  8  received data, LSB = first bit, unused upper bits 0
rx_valid  out  1  rx_data holds an unconsumed frame
rx_done  out  1  one-cycle pulse per completed frame
parity_err  out  1  parity mismatch for the frame in rx_data/last completed frame
frame_err  out  1  stop bit sampled low, or illegal length
overrun  out  1  frame in rx_data overwrote an unconsumed frame

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; bit counter 0; latched configuration cleared. rst is sampled only on tx_clk edges.
- Reset mid-frame: return to IDLE on that edge, discard the partial frame, clear the holding register. rx_done does not pulse.
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
  - IDLE: on an edge that samples rx=0, latch length, parity_en, parity_type and stop2, set bit_cnt=0, go to DATA. Configuration changes mid-frame are ignored.
  - DATA: each edge stores rx into data[bit_cnt] and increments bit_cnt. After the edge that samples bit length-1, go to PARITY if parity_en, else STOP1.
  - PARITY: sample rx; parity_err_next = (rx != expected). Expected = ^data[len-1:0] if parity_type, else ~^data[len-1:0]. Go to STOP1.
  - STOP1: rx=0 sets frame_err_next. If stop2, go to STOP2; else complete.
  - STOP2: rx=0 sets frame_err_next; complete.
  - Complete: on the final stop-bit edge, go to IDLE. If frame_err_next, go to WAIT_HIGH instead.
  - WAIT_HIGH: stay until rx is sampled 1, then go to IDLE. This prevents a held-low line (break) from being read as a stream of start bits.
- Illegal length (0-4, 9-15) latched at start: receive 8 data bits and force frame_err=1.
- Latency: rx_done, and rx_valid/rx_data update when loaded, are registered on the completion edge. They are visible the cycle after the final stop bit is sampled.
- A start bit on the cycle immediately after completion is accepted (back-to-back frames, zero gap).
- Handshake: a transfer occurs on an edge with rx_valid && rx_ready. On transfer without a new load, rx_valid, parity_err, frame_err and overrun all clear.
- Load while holding register empty or transferring on the same edge: load data/status, rx_valid=1, overrun=0.
- Load while rx_valid && !rx_ready: overwrite rx_data and status, overrun=1.
- With DROP_ERR=1, an errored frame:
  - leaves the holding register unchanged;
  - pulses rx_done;
  - drives parity_err/frame_err for that single cycle only.
- rx_data bits [7:length] are 0 for length<8.

Test Plan:
1. length=8, parity_en=1, parity_type=1, stop2=0; send 0xA5 with parity 0, stop 1. Required: rx_done one pulse; rx_data=0xA5; rx_valid=1; all error flags 0. Hold rx_ready=0: rx_valid stays 1. Assert rx_ready for one cycle: rx_valid=0.
2. Same frame with parity bit 1. Required: parity_err=1, rx_data=0xA5. Repeat with DROP_ERR=1: rx_valid stays 0, rx_done pulses.
3. length=5, parity_en=0, stop2=1; send 0x1F, second stop bit 0. Required: rx_data=0x1F, frame_err=1. With rx held low afterwards, no new frame starts until rx returns 1.
4. Two back-to-back frames 0x3C, 0xC3 with zero gap, rx_ready=0. Required: two rx_done pulses; rx_data=0xC3; overrun=1. Repeat with rx_ready=1 on the second completion edge: overrun=0.
5. Assert rst during bit 3 of a frame. Required: next cycle all outputs 0. The following complete frame 0x55 (length 8, no parity) is received correctly.
6. length=3 at start, 8 data bits 0x81 sent. Required: frame_err=1, rx_data=0x81.
